// File: rtl/soc_pm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_pm_ctrl (interface)
// Purpose  : Pixel-matrix control bundle driven by the PM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface soc_pm_ctrl;
    logic clkSh;
    logic shA;
    logic shB;
    logic res;
    logic strobe;
    logic write_cfg;
    logic gate;

    modport master (output clkSh, shA, shB, res, strobe, write_cfg, gate);
    modport slave  (input  clkSh, shA, shB, res, strobe, write_cfg, gate);
endinterface
`default_nettype wire

// File: rtl/soc_pm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : soc_pm_sequencer
// Purpose  : Turns single commands into cycle-exact pixel-matrix waveforms.
// Revision : 1.0 - initial release
// ============================================================================
module soc_pm_sequencer #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             cmd_valid,
    output logic                  cmd_ready,
    input  wire logic [1:0]       cmd_op,
    input  wire logic [LEN_W-1:0] cmd_len,
    input  wire logic             abort,
    output logic                  busy,
    output logic                  done,
    soc_pm_ctrl.master            ctrl
);

    localparam int                   c_PHASE_W    = $clog2(CLK_DIV + 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(CLK_DIV - 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_ONE  = c_PHASE_W'(1);
    localparam logic [LEN_W-1:0]     c_LEN_ONE    = LEN_W'(1);
    localparam logic [1:0]           c_OP_SHIFT   = 2'd0;
    localparam logic [1:0]           c_OP_WCFG    = 2'd1;
    localparam logic [1:0]           c_OP_STROBE  = 2'd2;
    localparam logic [1:0]           c_OP_GATE    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_op, w_op_nxt;
    logic [c_PHASE_W-1:0] r_phase, w_phase_nxt;
    logic [LEN_W-1:0]     r_cnt, w_cnt_nxt;

    logic r_clk_sh, r_sh_a, r_strobe, r_write_cfg, r_gate;
    logic r_busy, r_done, r_ready;
    logic w_clk_sh, w_sh_a, w_strobe, w_write_cfg, w_gate;
    logic w_phase_last, w_cnt_last;

    assign w_phase_last = (r_phase == c_PHASE_LAST);
    assign w_cnt_last   = (r_cnt == c_LEN_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op_nxt    = cmd_op;
                    w_cnt_nxt   = cmd_len;
                    w_phase_nxt = '0;
                    if (cmd_len == '0)
                        w_state_nxt = S_DONE;
                    else if (cmd_op == c_OP_SHIFT)
                        w_state_nxt = S_SETUP;
                    else if (cmd_op == c_OP_STROBE)
                        w_state_nxt = S_HIGH;
                    else
                        w_state_nxt = S_HOLD;
                end
            end
            S_SETUP, S_HIGH: begin
                if (w_phase_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = (r_state == S_SETUP) ? S_HIGH : S_LOW;
                end else begin
                    w_phase_nxt = r_phase + c_PHASE_ONE;
                end
            end
            S_LOW: begin
                if (w_phase_last) begin
                    w_phase_nxt = '0;
                    if (w_cnt_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt - c_LEN_ONE;
                        w_state_nxt = S_HIGH;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_PHASE_ONE;
                end
            end
            S_HOLD: begin
                if (w_cnt_last)
                    w_state_nxt = S_DONE;
                else
                    w_cnt_nxt = r_cnt - c_LEN_ONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort && (r_state != S_IDLE))
            w_state_nxt = S_IDLE;

        // Outputs are decoded from the next state so every ctrl line leaves a flop.
        w_sh_a      = (w_op_nxt == c_OP_SHIFT) &&
                      ((w_state_nxt == S_SETUP) || (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW));
        w_clk_sh    = (w_op_nxt == c_OP_SHIFT)  && (w_state_nxt == S_HIGH);
        w_strobe    = (w_op_nxt == c_OP_STROBE) && (w_state_nxt == S_HIGH);
        w_write_cfg = (w_op_nxt == c_OP_WCFG)   && (w_state_nxt == S_HOLD);
        w_gate      = (w_op_nxt == c_OP_GATE)   && (w_state_nxt == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= c_OP_SHIFT;
            r_phase     <= '0;
            r_cnt       <= '0;
            r_clk_sh    <= 1'b0;
            r_sh_a      <= 1'b0;
            r_strobe    <= 1'b0;
            r_write_cfg <= 1'b0;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clk_sh    <= w_clk_sh;
            r_sh_a      <= w_sh_a;
            r_strobe    <= w_strobe;
            r_write_cfg <= w_write_cfg;
            r_gate      <= w_gate;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_ready     <= (w_state_nxt == S_IDLE);
        end
    end

    assign cmd_ready      = r_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign ctrl.clkSh     = r_clk_sh;
    assign ctrl.shA       = r_sh_a;
    assign ctrl.shB       = 1'b0;
    assign ctrl.res       = 1'b0;
    assign ctrl.strobe    = r_strobe;
    assign ctrl.write_cfg = r_write_cfg;
    assign ctrl.gate      = r_gate;

endmodule
`default_nettype wire

// File: tb/tb_soc_pm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_pm_sequencer
// Purpose  : Directed self-checking bench for soc_pm_sequencer (CLK_DIV 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_pm_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_ready, a_abort, a_busy, a_done;
    logic [1:0]  a_op;
    logic [15:0] a_len;
    logic        b_valid, b_ready, b_abort, b_busy, b_done;
    logic [1:0]  b_op;
    logic [15:0] b_len;

    soc_pm_ctrl ifa ();
    soc_pm_ctrl ifb ();

    soc_pm_sequencer #(.CLK_DIV(2), .LEN_W(16)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(a_op), .cmd_len(a_len), .abort(a_abort),
        .busy(a_busy), .done(a_done), .ctrl(ifa)
    );

    soc_pm_sequencer #(.CLK_DIV(1), .LEN_W(16)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_len(b_len), .abort(b_abort),
        .busy(b_busy), .done(b_done), .ctrl(ifb)
    );

    // {clkSh, shA, shB, res, strobe, write_cfg, gate, busy, done, cmd_ready}
    logic [9:0] a_obs, b_obs;
    assign a_obs = {ifa.clkSh, ifa.shA, ifa.shB, ifa.res, ifa.strobe,
                    ifa.write_cfg, ifa.gate, a_busy, a_done, a_ready};
    assign b_obs = {ifb.clkSh, ifb.shA, ifb.shB, ifb.res, ifb.strobe,
                    ifb.write_cfg, ifb.gate, b_busy, b_done, b_ready};

    localparam logic [9:0] c_IDLE_VEC = 10'b0000000_001;

    int total = 0;
    int bad   = 0;

    task automatic start_a(input logic [1:0] op, input logic [15:0] len);
        @(negedge clk);
        a_valid = 1'b1;
        a_op    = op;
        a_len   = len;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (a_obs !== c_IDLE_VEC || b_obs !== c_IDLE_VEC) begin
            bad++;
            $display("FAIL reset_vals a=%b b=%b want=%b", a_obs, b_obs, c_IDLE_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_obs !== c_IDLE_VEC) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", a_obs, c_IDLE_VEC);
        end
        // Reset in the middle of a SHIFT behaves like an abort
        start_a(2'd0, 16'd3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
        end
        total++;
        if (a_busy !== 1'b1 || ifa.shA !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_busy got busy=%b shA=%b want busy=1 shA=1", a_busy, ifa.shA);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (a_obs !== c_IDLE_VEC) begin
            bad++;
            $display("FAIL reset_mid_shift got=%b want=%b", a_obs, c_IDLE_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_obs !== c_IDLE_VEC) begin
            bad++;
            $display("FAIL reset_mid_shift_after got=%b want=%b", a_obs, c_IDLE_VEC);
        end
    endtask

    task automatic test_shift();
        logic [9:0] exp;
        logic sha, clk_sh, bsy, dn, rdy;
        start_a(2'd0, 16'd3);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
            sha    = (c <= 14);
            clk_sh = (c == 3 || c == 4 || c == 7 || c == 8 || c == 11 || c == 12);
            bsy    = (c <= 15);
            dn     = (c == 15);
            rdy    = (c >= 16);
            exp    = {clk_sh, sha, 5'b00000, bsy, dn, rdy};
            total++;
            if (a_obs !== exp) begin
                bad++;
                $display("FAIL shift c=%0d got=%b want=%b", c, a_obs, exp);
            end
        end
    endtask

    task automatic test_strobe();
        logic [9:0] exp;
        logic stb, bsy, dn, rdy;
        @(negedge clk);
        b_valid = 1'b1;
        b_op    = 2'd2;
        b_len   = 16'd4;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) b_valid = 1'b0;
            stb = (c <= 7) && (c % 2 == 1);
            bsy = (c <= 9);
            dn  = (c == 9);
            rdy = (c >= 10);
            exp = {4'b0000, stb, 2'b00, bsy, dn, rdy};
            total++;
            if (b_obs !== exp) begin
                bad++;
                $display("FAIL strobe c=%0d got=%b want=%b", c, b_obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        logic wc, gt, bsy, dn, rdy;
        start_a(2'd1, 16'd1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            // Changing op/len after acceptance must not disturb the running WRITE_CFG
            if (c == 1) begin
                a_op  = 2'd3;
                a_len = 16'd5;
            end
            if (c == 4) a_valid = 1'b0;
            wc  = (c == 1);
            gt  = (c >= 4 && c <= 8);
            dn  = (c == 2 || c == 9);
            bsy = (c == 1 || c == 2 || (c >= 4 && c <= 9));
            rdy = (c == 3 || c == 10);
            exp = {5'b00000, wc, gt, bsy, dn, rdy};
            total++;
            if (a_obs !== exp) begin
                bad++;
                $display("FAIL back_to_back c=%0d got=%b want=%b", c, a_obs, exp);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [9:0] exp;
        logic act;
        start_a(2'd0, 16'd0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            act = (c % 2 == 1) && (c <= 5);
            exp = {7'b0000000, act, act, ~act};
            total++;
            if (a_obs !== exp) begin
                bad++;
                $display("FAIL zero_len c=%0d got=%b want=%b", c, a_obs, exp);
            end
            if (c == 6) a_valid = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [9:0] exp;
        logic sha, clk_sh, stb, bsy, dn, rdy;
        start_a(2'd0, 16'd10);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
            if (c == 7) a_abort = 1'b0;
            sha    = (c <= 6);
            clk_sh = (c == 3 || c == 4);
            bsy    = (c <= 6);
            rdy    = (c >= 7);
            exp    = {clk_sh, sha, 5'b00000, bsy, 1'b0, rdy};
            total++;
            if (a_obs !== exp) begin
                bad++;
                $display("FAIL abort c=%0d got=%b want=%b", c, a_obs, exp);
            end
            if (c == 6) a_abort = 1'b1;
        end
        // abort together with cmd_valid in IDLE: command is still accepted
        @(negedge clk);
        a_valid = 1'b1;
        a_op    = 2'd2;
        a_len   = 16'd1;
        a_abort = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_valid = 1'b0;
                a_abort = 1'b0;
            end
            stb = (c <= 2);
            bsy = (c <= 5);
            dn  = (c == 5);
            rdy = (c >= 6);
            exp = {4'b0000, stb, 2'b00, bsy, dn, rdy};
            total++;
            if (a_obs !== exp) begin
                bad++;
                $display("FAIL post_abort_strobe c=%0d got=%b want=%b", c, a_obs, exp);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0; a_op = 2'd0; a_len = 16'd0; a_abort = 1'b0;
        b_valid = 1'b0; b_op = 2'd0; b_len = 16'd0; b_abort = 1'b0;
        test_reset();
        test_shift();
        test_strobe();
        test_back_to_back();
        test_zero_len();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_pm_sequencer.md
# soc_pm_sequencer

Command-driven timing sequencer that drives the pixel-matrix control bundle (`soc_pm_ctrl`, master side). It sits between the SoC register bank / CPU bus and the pixel matrix. It turns single software commands into cycle-exact waveforms:

- `clkSh` shift trains with `shA` framing
- `strobe` pulse trains
- `write_cfg` latch pulses
- `gate` windows

Software issues one command and polls `busy` or waits for `done`; it never bit-bangs the control lines.

## Interface
Parameters:
- `CLK_DIV`, default 2: half-period of `clkSh`/`strobe` pulses, in `clk` cycles. Legal values are 1..255.
- `LEN_W`, default 16: width of the command length field.

Ports:
- `clk`  input  1  system clock. Single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `cmd_valid`  input  1  command request.
- `cmd_ready`  output  1  high only in IDLE. A command is accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_op`  input  2  opcode: 0 SHIFT, 1 WRITE_CFG, 2 STROBE, 3 GATE.
- `cmd_len`  input  LEN_W  pulse count (SHIFT, STROBE) or high-cycle count (WRITE_CFG, GATE).
- `abort`  input  1  synchronous cancel of the running command.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse on normal completion.
- `ctrl`  interface  soc_pm_ctrl.master  pixel-matrix control bundle. All members are driven from flops.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE.
- `cmd_op` and `cmd_len` are latched on acceptance and ignored afterwards.
- `ctrl.res` = 0 and `ctrl.shB` = 0 at all times.
- SHIFT:
  - IDLE -> SETUP: `shA`=1 and `clkSh`=0 for CLK_DIV cycles.
  - -> HIGH: `clkSh`=1 for CLK_DIV cycles.
  - -> LOW: `clkSh`=0 for CLK_DIV cycles.
  - The HIGH/LOW pair repeats `cmd_len` times, then -> DONE.
  - `shA` stays 1 from SETUP through the final LOW and drops to 0 in DONE.
- STROBE:
  - IDLE -> HIGH/LOW pairs as in SHIFT, driving `strobe` instead of `clkSh`.
  - No SETUP. `shA`=0 throughout.
- WRITE_CFG: IDLE -> HOLD with `write_cfg`=1 for `cmd_len` cycles -> DONE.
- GATE:
  - IDLE -> HOLD with `gate`=1 for `cmd_len` cycles -> DONE.
  - `shA`=0 throughout, so the pixels register a new random value on the gate falling edge.
- `cmd_len` = 0, any opcode: IDLE -> DONE directly. No control line toggles. `done` still pulses.
- DONE: all control outputs 0, `done`=1 for one cycle -> IDLE.
- Counters:
  - Phase counter counts 0..CLK_DIV-1, width $clog2(CLK_DIV+1).
  - Pulse/hold counter is LEN_W bits and counts down from `cmd_len`.
  - The counters never wrap. `cmd_len` = 2^LEN_W-1 runs to completion.
- `abort`, when not in IDLE:
  - The next state is IDLE, with all control outputs 0 and `busy` 0.
  - `done` is not pulsed.
  - `abort` in IDLE is ignored.
  - If `abort` and `cmd_valid` are both high in IDLE, the command is accepted.
- Reset mid-command is treated as an abort.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, every `ctrl` member 0.
- Acceptance happens on cycle 0. The first waveform cycle and `busy`=1 appear on cycle 1.
- Busy length, cycles 1..last with DONE included:
  - SHIFT: CLK_DIV*(2N+1)+1.
  - STROBE: 2*CLK_DIV*N+1.
  - WRITE_CFG and GATE: N+1.
  - N=0: 1.
- `cmd_ready` returns to 1 in the cycle after DONE. A back-to-back command can be accepted in that cycle and starts on the following one.
- `clkSh` and `strobe` have a 50 % duty cycle with period 2*CLK_DIV. `shA` is stable for CLK_DIV cycles before the first `clkSh` rise and after the last `clkSh` fall.
- `abort` sampled high on cycle k: outputs are 0 and the state is IDLE on cycle k+1.

## Test plan
- Reset, then idle: every `ctrl` member 0, `cmd_ready`=1, `busy`=0. Repeat with reset asserted mid-SHIFT: same values on the cycle after reset.
- CLK_DIV=2, SHIFT N=3 accepted on cycle 0:
  - `shA`=1 on cycles 1–14.
  - `clkSh`=1 on cycles 3–4, 7–8 and 11–12.
  - `done`=1 and `shA`=0 on cycle 15.
  - `cmd_ready`=1 on cycle 16.
- CLK_DIV=1, STROBE N=4: `strobe` high on cycles 1, 3, 5, 7; `shA`=0 throughout; `done` on cycle 9.
- WRITE_CFG N=1 followed back-to-back by GATE N=5:
  - `write_cfg` high on cycle 1, `done` on cycle 2.
  - GATE is accepted on cycle 3.
  - `gate` high on cycles 4–8, `done` on cycle 9.
- SHIFT N=0: `done` on cycle 1, no `clkSh`/`shA` activity. Also `cmd_valid` held high while busy: exactly one command is accepted per IDLE visit.
- Abort: SHIFT N=10 with `abort` pulsed on cycle 6.
  - Cycle 7: all outputs 0, `busy`=0, `cmd_ready`=1.
  - `done` never asserts.
  - A subsequent STROBE N=1 executes normally.
